branch_predictor: RTL and testbench

- Parametrised branch predictor for the 5-stage core: a tagged BTB plus a table of saturating direction counters.
- Selectable bimodal or gshare indexing; successor to the fixed predictor inside the fetch stage.
- Fetch side: combinational lookup on the current PC, giving predicted direction and next PC in the same cycle.
- Execute side: the resolved branch outcome trains the tables; the block also keeps branch and mispredict counts for debug readout.

---
 rtl/bp_pkg.sv | 58 +++++
 rtl/branch_predictor_sat_counter_array.sv | 51 +++++
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor.
//   bp_entry_t   - one BTB entry as seen by the lookup path (valid, tag, target).
//                  The tag field is 32 bits wide. Narrower stored tags are
//                  zero-extended into it.
//   ctr_op_t     - write operation for the saturating counter array.
//   ctr_init_nt  - weakly not-taken counter value for a given counter width.
//   ctr_init_t   - weakly taken counter value for a given counter width.
//   ctr_max      - saturated value for a given counter width.
//   bp_index     - table index from a PC, optionally XORed with global history.
//   bp_tag       - tag bits taken from just above the index field of a PC.
package bp_pkg;

  localparam int MAX_CTR_WID = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } bp_entry_t;

  typedef enum logic [1:0] {
    CTR_INC  = 2'd0,
    CTR_DEC  = 2'd1,
    CTR_LOAD = 2'd2
  } ctr_op_t;

  function automatic logic [MAX_CTR_WID-1:0] ctr_init_nt(input int ctr_wid);
    return MAX_CTR_WID'((1 << (ctr_wid - 1)) - 1);
  endfunction

  function automatic logic [MAX_CTR_WID-1:0] ctr_init_t(input int ctr_wid);
    return MAX_CTR_WID'(1 << (ctr_wid - 1));
  endfunction

  function automatic logic [MAX_CTR_WID-1:0] ctr_max(input int ctr_wid);
    return MAX_CTR_WID'((1 << ctr_wid) - 1);
  endfunction

  // Word-aligned PCs, so the index starts at bit 2. In gshare mode the
  // history is XORed into the low index bits.
  function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr,
                                           input int idx_wid, input int mode);
    logic [31:0] mask;
    mask = (32'd1 << idx_wid) - 32'd1;
    if (mode == 1)
      return ((pc >> 2) ^ ghr) & mask;
    else
      return (pc >> 2) & mask;
  endfunction

  function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_wid,
                                         input int tag_wid);
    logic [63:0] mask;
    mask = (64'd1 << tag_wid) - 64'd1;
    return 32'((64'(pc) >> (idx_wid + 2)) & mask);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_array.sv
// sat_counter_array: ENTRIES saturating up/down counters.
//   clk, rst  - clock, asynchronous active-high reset (counters -> weakly not-taken)
//   rd_idx    - combinational read port index; rd_ctr is the counter value
//   wr_en     - apply wr_op to entry wr_idx at the clock edge
//   wr_op     - CTR_INC / CTR_DEC (both saturating) or CTR_LOAD (load wr_load)
module sat_counter_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_WID = 6,
  parameter int CTR_WID = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_WID-1:0] rd_idx,
  output logic [CTR_WID-1:0] rd_ctr,
  input  logic               wr_en,
  input  logic [IDX_WID-1:0] wr_idx,
  input  ctr_op_t            wr_op,
  input  logic [CTR_WID-1:0] wr_load
);

  localparam logic [CTR_WID-1:0] INIT_NT = CTR_WID'(ctr_init_nt(CTR_WID));
  localparam logic [CTR_WID-1:0] CTR_MAX = CTR_WID'(ctr_max(CTR_WID));

  logic [CTR_WID-1:0] ctr_all [ENTRIES];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      logic [CTR_WID-1:0] ctr_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctr_reg <= INIT_NT;
        end else if (wr_en && (wr_idx == IDX_WID'(gi))) begin
          case (wr_op)
            CTR_INC:  if (ctr_reg != CTR_MAX) ctr_reg <= ctr_reg + CTR_WID'(1);
            CTR_DEC:  if (ctr_reg != '0)      ctr_reg <= ctr_reg - CTR_WID'(1);
            CTR_LOAD: ctr_reg <= wr_load;
            default:  ctr_reg <= ctr_reg;
          endcase
        end
      end

      assign ctr_all[gi] = ctr_reg;
    end
  endgenerate

  assign rd_ctr = ctr_all[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: tagged BTB plus saturating direction counters.
// It uses bimodal indexing (MODE=0) or gshare indexing (MODE=1).
//   clk, rst        - core clock, asynchronous active-high reset
//   stall           - freezes all tables, history and statistics
//   lookup_pc       - IF-stage PC. predict_taken/predict_pc are combinational.
//   upd_*           - resolved instruction from EX, used for training
//   branch_cnt      - resolved branches since reset (saturating)
//   mispredict_cnt  - mispredicted branches since reset (saturating)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_WID = 8,
  parameter int CTR_WID = 2,
  parameter int MODE    = 0,
  parameter int GHR_WID = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic [31:0] predict_pc,
  input  logic        upd_valid,
  input  logic        upd_branch,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int IDX_WID = $clog2(ENTRIES);

  logic [GHR_WID-1:0] ghr_reg, ghr_next;
  logic [ENTRIES-1:0] valid_reg;
  logic [TAG_WID-1:0] tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [31:0]        branch_cnt_reg, mispredict_cnt_reg;

  logic [IDX_WID-1:0] lookup_idx, upd_idx;
  logic [TAG_WID-1:0] lookup_tag, upd_tag;
  logic [CTR_WID-1:0] lookup_ctr;
  bp_entry_t          lookup_entry;
  logic               lookup_hit, upd_hit, do_upd, ctr_wr_en;
  ctr_op_t            ctr_op;

  // The lookup and update paths use the same registered history. Both
  // therefore index the same way within a cycle.
  assign lookup_idx = IDX_WID'(bp_index(lookup_pc, 32'(ghr_reg), IDX_WID, MODE));
  assign lookup_tag = TAG_WID'(bp_tag(lookup_pc, IDX_WID, TAG_WID));
  assign upd_idx    = IDX_WID'(bp_index(upd_pc, 32'(ghr_reg), IDX_WID, MODE));
  assign upd_tag    = TAG_WID'(bp_tag(upd_pc, IDX_WID, TAG_WID));

  always_comb begin
    lookup_entry        = '0;
    lookup_entry.valid  = valid_reg[lookup_idx];
    lookup_entry.tag    = 32'(tag_mem[lookup_idx]);
    lookup_entry.target = target_mem[lookup_idx];
  end

  assign lookup_hit    = lookup_entry.valid && (lookup_entry.tag == 32'(lookup_tag));
  assign predict_taken = lookup_hit & lookup_ctr[CTR_WID-1];
  assign predict_pc    = predict_taken ? lookup_entry.target : lookup_pc + 32'd4;

  assign do_upd  = upd_valid & upd_branch & ~stall;
  assign upd_hit = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  // A miss with a not-taken outcome leaves the counter untouched. A miss
  // with a taken outcome reallocates the entry as weakly taken.
  assign ctr_wr_en = do_upd & (upd_hit | upd_taken);
  assign ctr_op    = upd_hit ? (upd_taken ? CTR_INC : CTR_DEC) : CTR_LOAD;

  sat_counter_array #(
    .ENTRIES (ENTRIES),
    .IDX_WID (IDX_WID),
    .CTR_WID (CTR_WID)
  ) u_ctrs (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (lookup_idx),
    .rd_ctr  (lookup_ctr),
    .wr_en   (ctr_wr_en),
    .wr_idx  (upd_idx),
    .wr_op   (ctr_op),
    .wr_load (CTR_WID'(ctr_init_t(CTR_WID)))
  );

  generate
    if (GHR_WID > 1) begin : g_ghr_shift
      assign ghr_next = {ghr_reg[GHR_WID-2:0], upd_taken};
    end else begin : g_ghr_bit
      assign ghr_next = upd_taken;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_reg            <= '0;
      valid_reg          <= '0;
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else if (do_upd) begin
      if (MODE == 1) ghr_reg <= ghr_next;
      if (upd_taken) valid_reg[upd_idx] <= 1'b1;
      if (branch_cnt_reg != 32'hFFFF_FFFF) branch_cnt_reg <= branch_cnt_reg + 32'd1;
      if (upd_mispredict && (mispredict_cnt_reg != 32'hFFFF_FFFF))
        mispredict_cnt_reg <= mispredict_cnt_reg + 32'd1;
    end
  end

  // Tag and target storage need no reset because valid_reg gates every use.
  always_ff @(posedge clk) begin
    if (do_upd && upd_taken) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= upd_target;
    end
  end

  assign branch_cnt     = branch_cnt_reg;
  assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, stall;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic        upd_valid_a, upd_valid_b, upd_branch, upd_taken, upd_mispredict;
  logic        pt_a, pt_b;
  logic [31:0] pp_a, pp_b, bc_a, bc_b, mc_a, mc_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor dut_a (
    .clk(clk), .rst(rst_a), .stall(stall), .lookup_pc(lookup_pc),
    .predict_taken(pt_a), .predict_pc(pp_a), .upd_valid(upd_valid_a),
    .upd_branch(upd_branch), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .branch_cnt(bc_a), .mispredict_cnt(mc_a)
  );

  branch_predictor #(.MODE(1), .GHR_WID(6)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall), .lookup_pc(lookup_pc),
    .predict_taken(pt_b), .predict_pc(pp_b), .upd_valid(upd_valid_b),
    .upd_branch(upd_branch), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .branch_cnt(bc_b), .mispredict_cnt(mc_b)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  task automatic look(input bit on_b, input string name, input logic [31:0] pc,
                      input logic exp_t, input logic [31:0] exp_pc);
    @(negedge clk);
    lookup_pc = pc;
    #1;
    check({name, "_taken"}, on_b ? {31'b0, pt_b} : {31'b0, pt_a}, {31'b0, exp_t});
    check({name, "_pc"}, on_b ? pp_b : pp_a, exp_pc);
  endtask

  task automatic do_upd(input bit on_b, input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt, input logic mp);
    @(negedge clk);
    upd_branch = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispredict = mp;
    if (on_b) upd_valid_b = 1'b1; else upd_valid_a = 1'b1;
    $display("upd dut=%s pc=%h taken=%0d target=%h mispredict=%0d",
             on_b ? "gshare" : "bimodal", pc, taken, tgt, mp);
    @(negedge clk);
    upd_valid_a = 1'b0; upd_valid_b = 1'b0; upd_branch = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; stall = 1'b0;
    upd_valid_a = 1'b0; upd_valid_b = 1'b0; upd_branch = 1'b0; upd_taken = 1'b0;
    upd_mispredict = 1'b0; upd_pc = '0; upd_target = '0; lookup_pc = 32'h1c090040;
    repeat (2) @(negedge clk);

    // Values while reset is held.
    look(0, "rst_a", 32'h1c090040, 1'b0, 32'h1c090044);
    check("rst_bc_a", bc_a, 32'd0);
    check("rst_mc_a", mc_a, 32'd0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    look(0, "post_rst_a", 32'h1c090040, 1'b0, 32'h1c090044);

    // Allocate on a taken miss. The new entry is weakly taken.
    do_upd(0, 32'h1c090040, 1'b1, 32'h1c090000, 1'b1);
    look(0, "alloc", 32'h1c090040, 1'b1, 32'h1c090000);
    check("bc_1", bc_a, 32'd1);
    check("mc_1", mc_a, 32'd1);

    // Two not-taken updates: counter goes 2 -> 1 -> 0.
    do_upd(0, 32'h1c090040, 1'b0, 32'h0, 1'b0);
    look(0, "nt1", 32'h1c090040, 1'b0, 32'h1c090044);
    do_upd(0, 32'h1c090040, 1'b0, 32'h0, 1'b0);
    look(0, "nt2", 32'h1c090040, 1'b0, 32'h1c090044);

    // Five taken updates: counter goes 0 -> 1 -> 2 -> 3, then stays at 3.
    // Each hit also refreshes the target.
    do_upd(0, 32'h1c090040, 1'b1, 32'h1c090100, 1'b0);
    look(0, "t1", 32'h1c090040, 1'b0, 32'h1c090044);
    do_upd(0, 32'h1c090040, 1'b1, 32'h1c090100, 1'b0);
    look(0, "t2", 32'h1c090040, 1'b1, 32'h1c090100);
    repeat (3) do_upd(0, 32'h1c090040, 1'b1, 32'h1c090100, 1'b0);
    do_upd(0, 32'h1c090040, 1'b0, 32'h0, 1'b0);
    look(0, "sat_nt", 32'h1c090040, 1'b1, 32'h1c090100);
    check("bc_9", bc_a, 32'd9);

    // Aliasing: same index, different tag. The newer branch overwrites the entry.
    do_upd(0, 32'h1c094040, 1'b1, 32'h1c098000, 1'b0);
    look(0, "alias_old", 32'h1c090040, 1'b0, 32'h1c090044);
    look(0, "alias_new", 32'h1c094040, 1'b1, 32'h1c098000);

    // A mispredict flag without a branch is ignored.
    @(negedge clk);
    upd_valid_a = 1'b1; upd_branch = 1'b0; upd_mispredict = 1'b1; upd_pc = 32'h1c090080;
    @(negedge clk);
    upd_valid_a = 1'b0; upd_mispredict = 1'b0;
    check("nobranch_bc", bc_a, 32'd10);
    check("nobranch_mc", mc_a, 32'd1);

    // A not-taken miss does not allocate an entry.
    do_upd(0, 32'h1c090080, 1'b0, 32'h1c090200, 1'b0);
    look(0, "miss_nt", 32'h1c090080, 1'b0, 32'h1c090084);
    check("bc_11", bc_a, 32'd11);

    // Stall held for 3 cycles with an update pending, then released.
    @(negedge clk);
    stall = 1'b1; upd_valid_a = 1'b1; upd_branch = 1'b1; upd_pc = 32'h1c090080;
    upd_taken = 1'b1; upd_target = 32'h1c090200; upd_mispredict = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_bc", bc_a, 32'd11);
    check("stall_mc", mc_a, 32'd1);
    #1;
    lookup_pc = 32'h1c090080;
    #1;
    check("stall_tbl", {31'b0, pt_a}, 32'd0);
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    upd_valid_a = 1'b0; upd_branch = 1'b0; upd_mispredict = 1'b0;
    check("unstall_bc", bc_a, 32'd12);
    check("unstall_mc", mc_a, 32'd2);
    look(0, "unstall_tbl", 32'h1c090080, 1'b1, 32'h1c090200);

    // Same-cycle lookup and update: the lookup sees the pre-update contents.
    @(negedge clk);
    lookup_pc = 32'h1c0900c0;
    upd_valid_a = 1'b1; upd_branch = 1'b1; upd_pc = 32'h1c0900c0;
    upd_taken = 1'b1; upd_target = 32'h1c090300;
    #1;
    check("same_cyc_pre", pp_a, 32'h1c0900c4);
    @(negedge clk);
    upd_valid_a = 1'b0; upd_branch = 1'b0;
    #1;
    check("same_cyc_post", pp_a, 32'h1c090300);

    // The PC+4 addition wraps at the top of the address space.
    look(0, "wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // gshare: three taken branches build ghr=0b000111. The third allocates
    // index 20^3=23, which is where 0x1c090040 (16^7) now points.
    do_upd(1, 32'h1c090040, 1'b1, 32'h1c0a1000, 1'b0);
    do_upd(1, 32'h1c090040, 1'b1, 32'h1c0a1000, 1'b0);
    do_upd(1, 32'h1c090050, 1'b1, 32'h1c0a0000, 1'b0);
    look(1, "gs_idx23", 32'h1c090040, 1'b1, 32'h1c0a0000);
    look(1, "gs_idx19", 32'h1c090050, 1'b0, 32'h1c090054);
    check("gs_bc", bc_b, 32'd3);

    // Asynchronous reset: the effect is visible before any clock edge.
    @(negedge clk);
    rst_b = 1'b1;
    lookup_pc = 32'h1c090040;
    #1;
    check("gs_rst_taken", {31'b0, pt_b}, 32'd0);
    check("gs_rst_pc", pp_b, 32'h1c090044);
    check("gs_rst_bc", bc_b, 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    look(1, "gs_post_rst", 32'h1c090040, 1'b0, 32'h1c090044);

    // With ghr back at 0, the allocation lands at index 16 and ghr becomes 1.
    // Then 0x1c090044 (17^1=16) hits.
    do_upd(1, 32'h1c090040, 1'b1, 32'h1c0b0000, 1'b0);
    look(1, "gs_ghr_cleared", 32'h1c090044, 1'b1, 32'h1c0b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
